// File: rtl/icache_direct_mapped_pkg.sv
// rtl/icache_direct_mapped_pkg.sv - shared types and constants for the direct-mapped instruction cache
package icache_direct_mapped_pkg;

    localparam int LINE_WORDS = 4;
    localparam int OFF_W      = 2;
    localparam int LINE_BITS  = LINE_WORDS * 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    function automatic logic [31:0] line_word(input logic [LINE_BITS-1:0] line,
                                              input logic [OFF_W-1:0]     off);
        return line[off*32 +: 32];
    endfunction

endpackage

// File: rtl/icache_direct_mapped_if.sv
// rtl/icache_direct_mapped_if.sv - fetch-side and refill-side signals of the instruction cache
interface icache_direct_mapped_if #(
    parameter int ADDR_W = 30
);
    logic              proc_read;
    logic [ADDR_W-1:0] proc_addr;
    logic [31:0]       proc_rdata;
    logic              proc_stall;
    logic              mem_read;
    logic [ADDR_W-3:0] mem_addr;
    logic [127:0]      mem_rdata;
    logic              mem_ready;

    modport slave (
        input  proc_read, proc_addr, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_addr
    );

    modport master (
        output proc_read, proc_addr, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_addr
    );
endinterface

// File: rtl/icache_line_array.sv
// rtl/icache_line_array.sv - register-based valid/tag/data storage, one read and one write port
module icache_line_array
    import icache_direct_mapped_pkg::*;
#(
    parameter  int LINES = 8,
    parameter  int TAG_W = 25,
    localparam int IDX_W = $clog2(LINES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_valid,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [LINE_BITS-1:0] rd_line,
    input  logic                 we,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [TAG_W-1:0]     wr_tag,
    input  logic [LINE_BITS-1:0] wr_line
);

    logic [LINES-1:0]     valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q  [LINES];
    logic [TAG_W-1:0]     tag_d  [LINES];
    logic [LINE_BITS-1:0] data_q [LINES];
    logic [LINE_BITS-1:0] data_d [LINES];

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (we) begin
            valid_d[wr_idx] = 1'b1;
            tag_d[wr_idx]   = wr_tag;
            data_d[wr_idx]  = wr_line;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/icache_direct_mapped.sv
// rtl/icache_direct_mapped.sv - read-only direct-mapped instruction cache with whole-line refill
module icache_direct_mapped
    import icache_direct_mapped_pkg::*;
#(
    parameter int LINES  = 8,
    parameter int ADDR_W = 30,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    icache_direct_mapped_if.slave bus,
    output logic [CNT_W-1:0]     miss_count
);

    localparam int IDX_W   = $clog2(LINES);
    localparam int TAG_W   = ADDR_W - IDX_W - OFF_W;
    localparam int LADDR_W = ADDR_W - OFF_W;

    state_e               state_q, state_d;
    logic [LADDR_W-1:0]   miss_addr_q, miss_addr_d;
    logic [CNT_W-1:0]     miss_count_q, miss_count_d;

    logic [OFF_W-1:0]     offset;
    logic [IDX_W-1:0]     index;
    logic [TAG_W-1:0]     tag;
    logic                 rd_valid;
    logic [TAG_W-1:0]     rd_tag;
    logic [LINE_BITS-1:0] rd_line;
    logic                 hit;
    logic                 we;
    logic                 stall;
    logic                 mem_read;
    logic [31:0]          rdata;

    assign offset = bus.proc_addr[OFF_W-1:0];
    assign index  = bus.proc_addr[IDX_W+OFF_W-1:OFF_W];
    assign tag    = bus.proc_addr[ADDR_W-1:IDX_W+OFF_W];

    icache_line_array #(
        .LINES (LINES),
        .TAG_W (TAG_W)
    ) u_lines (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .we       (we),
        .wr_idx   (miss_addr_q[IDX_W-1:0]),
        .wr_tag   (miss_addr_q[LADDR_W-1:IDX_W]),
        .wr_line  (bus.mem_rdata)
    );

    assign hit = bus.proc_read && rd_valid && (rd_tag == tag);

    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        miss_count_d = miss_count_q;
        stall        = 1'b0;
        mem_read     = 1'b0;
        we           = 1'b0;
        rdata        = 32'h0;
        case (state_q)
            S_IDLE: begin
                if (bus.proc_read) begin
                    if (hit) begin
                        rdata = line_word(rd_line, offset);
                    end else begin
                        stall       = 1'b1;
                        miss_addr_d = bus.proc_addr[ADDR_W-1:OFF_W];
                        if (miss_count_q != '1) begin
                            miss_count_d = miss_count_q + CNT_W'(1);
                        end
                        state_d = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                stall    = 1'b1;
                mem_read = 1'b1;
                if (bus.mem_ready) begin
                    we      = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // One settle cycle so the re-presented address hits the freshly written line.
                stall   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            miss_addr_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign bus.proc_stall = stall;
    assign bus.proc_rdata = rdata;
    assign bus.mem_read   = mem_read;
    assign bus.mem_addr   = miss_addr_q;
    assign miss_count     = miss_count_q;

endmodule
